// File: rtl/led_ctrl_pkg.sv
// Shared types and parameter defaults for the multi-channel LED blink controller.
package led_ctrl_pkg;

  localparam int unsigned DEF_NUM_CH   = 4;
  localparam int unsigned DEF_PRESCALE = 50;
  localparam int unsigned DEF_CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/led_blink_ctrl_tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE and flags the terminal count as a tick.
module tick_gen
  import led_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(PRESCALE));
  assign tick   = w_wrap;

  always_ff @(posedge clk) begin
    if (reset)       r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// NUM_CH independent on/off blink sequencers sharing one free-running tick prescaler.
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_on,
  input  logic [CNT_W-1:0]  cfg_off,
  input  logic [CNT_W-1:0]  cfg_repeat,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  localparam int unsigned RDY_W = 2 ** CH_W;

  logic              w_tick;
  logic [NUM_CH-1:0] w_rdy;
  logic [RDY_W-1:0]  w_rdy_all;

  function automatic logic [CNT_W-1:0] f_at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Padded so an unused cfg_ch code reads as not-ready.
  assign w_rdy_all = RDY_W'(w_rdy);
  assign cfg_ready = w_rdy_all[cfg_ch];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_phase, w_phase_nxt;
    logic [CNT_W-1:0] r_rep,   w_rep_nxt;
    logic [CNT_W-1:0] r_on,    w_on_nxt;
    logic [CNT_W-1:0] r_off,   w_off_nxt;
    logic             r_forever, w_forever_nxt;
    logic             w_done_nxt, w_acc;
    logic             r_led, r_busy, r_done;

    assign w_rdy[i] = (r_state == IDLE) && !stop[i];
    assign w_acc    = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    assign led[i]   = r_led;
    assign busy[i]  = r_busy;
    assign done[i]  = r_done;

    always_comb begin
      w_state_nxt   = r_state;
      w_phase_nxt   = r_phase;
      w_rep_nxt     = r_rep;
      w_on_nxt      = r_on;
      w_off_nxt     = r_off;
      w_forever_nxt = r_forever;
      w_done_nxt    = 1'b0;
      if (stop[i]) begin
        w_state_nxt   = IDLE;
        w_phase_nxt   = '0;
        w_rep_nxt     = '0;
        w_on_nxt      = '0;
        w_off_nxt     = '0;
        w_forever_nxt = 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_acc) begin
              w_state_nxt   = ON;
              w_phase_nxt   = f_at_least_one(cfg_on);
              w_rep_nxt     = cfg_repeat;
              w_on_nxt      = cfg_on;
              w_off_nxt     = cfg_off;
              w_forever_nxt = (cfg_repeat == '0);
            end
          end
          ON, OFF: begin
            if (w_tick) begin
              if (r_phase != CNT_W'(1)) begin
                w_phase_nxt = r_phase - CNT_W'(1);
              end else if ((r_state == ON) && (r_off != '0)) begin
                w_state_nxt = OFF;
                w_phase_nxt = r_off;
              end else if (r_forever || (r_rep > CNT_W'(1))) begin
                // An ON with zero off length falls through here as if its OFF ended.
                w_state_nxt = ON;
                w_phase_nxt = f_at_least_one(r_on);
                if (!r_forever) w_rep_nxt = r_rep - CNT_W'(1);
              end else begin
                w_state_nxt   = IDLE;
                w_phase_nxt   = '0;
                w_rep_nxt     = '0;
                w_on_nxt      = '0;
                w_off_nxt     = '0;
                w_forever_nxt = 1'b0;
                w_done_nxt    = 1'b1;
              end
            end
          end
          default: w_state_nxt = IDLE;
        endcase
      end
    end

    // Outputs are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state   <= IDLE;
        r_phase   <= '0;
        r_rep     <= '0;
        r_on      <= '0;
        r_off     <= '0;
        r_forever <= 1'b0;
        r_led     <= 1'b0;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_phase   <= w_phase_nxt;
        r_rep     <= w_rep_nxt;
        r_on      <= w_on_nxt;
        r_off     <= w_off_nxt;
        r_forever <= w_forever_nxt;
        r_led     <= (w_state_nxt == ON);
        r_busy    <= (w_state_nxt != IDLE);
        r_done    <= w_done_nxt;
      end
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Randomized and directed checks of led_blink_ctrl against a phase-queue reference model.
module tb_led_blink_ctrl;

  localparam int NCH = 4;
  localparam int PS  = 3;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_on, cfg_off, cfg_repeat;
  logic [NCH-1:0] stop;
  logic [NCH-1:0] led, busy, done;

  led_blink_ctrl #(.NUM_CH(NCH), .PRESCALE(PS), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_on     (cfg_on),
    .cfg_off    (cfg_off),
    .cfg_repeat (cfg_repeat),
    .stop       (stop),
    .led        (led),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each channel holds a queue of pending phases in ticks (+n lit, -n dark).
  int             mq [NCH][$];
  bit             m_forever [NCH];
  int             m_on [NCH];
  int             m_off [NCH];
  logic [NCH-1:0] m_done;
  int             m_pc;

  function automatic void refill(input int ch);
    mq[ch].push_back((m_on[ch] == 0) ? 1 : m_on[ch]);
    if (m_off[ch] != 0) mq[ch].push_back(-m_off[ch]);
  endfunction

  function automatic void model_edge(input bit rst, input logic [NCH-1:0] stp, input bit acc,
                                     input int ach, input int on, input int off, input int rep,
                                     input bit tk);
    int f;
    m_done = '0;
    if (rst) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_pc = 0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      if (stp[c]) mq[c].delete();
      else if (tk && mq[c].size() > 0) begin
        f = mq[c][0];
        f = (f > 0) ? f - 1 : f + 1;
        if (f != 0) mq[c][0] = f;
        else begin
          void'(mq[c].pop_front());
          if (mq[c].size() == 0) begin
            if (m_forever[c]) refill(c);
            else m_done[c] = 1'b1;
          end
        end
      end
    end
    if (acc) begin
      m_on[ach]      = on;
      m_off[ach]     = off;
      m_forever[ach] = (rep == 0);
      for (int k = 0; k < ((rep == 0) ? 1 : rep); k++) refill(ach);
    end
    m_pc = (m_pc == PS) ? 0 : m_pc + 1;
  endfunction

  task automatic cycle();
    logic [NCH-1:0] e_led, e_busy, s_stop;
    bit rdy, tk, acc, s_rst;
    int ch, s_on, s_off, s_rep;
    #1;
    ch    = int'(cfg_ch);
    rdy   = (mq[ch].size() == 0) && !stop[ch];
    if (!reset) check("cfg_ready", 32'(cfg_ready), 32'(rdy));
    tk    = (m_pc == PS);
    acc   = cfg_valid && rdy;
    s_rst = reset; s_stop = stop;
    s_on  = int'(cfg_on); s_off = int'(cfg_off); s_rep = int'(cfg_repeat);
    @(posedge clk);
    model_edge(s_rst, s_stop, acc, ch, s_on, s_off, s_rep, tk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      e_busy[c] = (mq[c].size() != 0);
      e_led[c]  = e_busy[c] && (mq[c][0] > 0);
    end
    check("led", 32'(led), 32'(e_led));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; cfg_ch = '0; cfg_on = '0; cfg_off = '0; cfg_repeat = '0; stop = '0;
  endtask

  task automatic drive_cfg(input int ch, input int on, input int off, input int rep);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_on = CW'(on); cfg_off = CW'(off); cfg_repeat = CW'(rep);
  endtask

  initial begin
    int hi_cnt, done_k, fall_k, guard;
    m_pc = 0;
    for (int c = 0; c < NCH; c++) begin m_forever[c] = 0; m_on[c] = 0; m_off[c] = 0; end
    m_done = '0;
    idle_inputs();
    reset = 1'b1;
    repeat (3) cycle();
    check("rst_led", 32'(led), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Align the ch0 accept with a tick.
    guard = 0;
    while (m_pc != PS && guard < 8) begin cycle(); guard++; end
    check("align_guard", 32'(guard < 8), 32'd1);
    drive_cfg(0, 2, 1, 2);
    cycle();
    idle_inputs();
    hi_cnt = 32'(led[0]); done_k = -1; fall_k = -1;
    for (int k = 1; k < 30; k++) begin
      if (k == 2) begin
        drive_cfg(0, 1, 1, 1);
        #1 check("rdy_busy_ch0", 32'(cfg_ready), 32'd0);
      end
      if (k == 3) drive_cfg(2, 1, 1, 1);
      if (k == 4) drive_cfg(1, 1, 0, 0);
      cycle();
      idle_inputs();
      hi_cnt += 32'(led[0]);
      if (done[0] && done_k < 0) done_k = k;
      if (!busy[0] && fall_k < 0) fall_k = k;
    end
    check("ch0_lit_cycles", 32'(hi_cnt), 32'd16);
    check("ch0_done_cycle", 32'(done_k), 32'd24);
    check("ch0_busy_fall", 32'(fall_k), 32'd24);
    check("ch1_forever_led", 32'(led[1]), 32'd1);

    stop[1] = 1'b1;
    cycle();
    idle_inputs();
    check("ch1_stop_led", 32'(led[1]), 32'd0);
    check("ch1_stop_busy", 32'(busy[1]), 32'd0);
    check("ch1_stop_done", 32'(done[1]), 32'd0);

    drive_cfg(3, 2, 2, 1);
    stop[3] = 1'b1;
    #1 check("rdy_stop_ch3", 32'(cfg_ready), 32'd0);
    cycle();
    idle_inputs();
    check("ch3_stays_idle", 32'(busy[3]), 32'd0);
    drive_cfg(3, 5, 5, 3);
    cycle();
    idle_inputs();
    repeat (3) cycle();
    check("ch3_mid_on", 32'(led[3]), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("ch3_rst_led", 32'(led[3]), 32'd0);
    check("ch3_rst_done", 32'(done), 32'd0);

    for (int n = 0; n < 4000; n++) begin
      idle_inputs();
      if ($urandom_range(99) < 35)
        drive_cfg($urandom_range(NCH - 1), $urandom_range(4), $urandom_range(3), $urandom_range(3));
      for (int c = 0; c < NCH; c++) stop[c] = ($urandom_range(199) < 3);
      reset = ($urandom_range(999) < 3);
      cycle();
    end
    reset = 1'b0;
    idle_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_blink_ctrl.md
LED_BLINK_CTRL -- requirements
Module: led_blink_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of independent LED channels.
REQ-002 SHALL have parameter PRESCALE, default 50; tick period is PRESCALE+1 clk cycles.
REQ-003 SHALL have parameter CNT_W, default 8, the width of the on, off and repeat fields.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_valid  input  1  config request present.
REQ-007 cfg_ready  output  1  config accepted this cycle if cfg_valid.
REQ-008 cfg_ch  input  clog2(NUM_CH)  target channel.
REQ-009 cfg_on  input  CNT_W  on-phase length in ticks.
REQ-010 cfg_off  input  CNT_W  off-phase length in ticks.
REQ-011 cfg_repeat  input  CNT_W  on/off cycle count; 0 = run forever.
REQ-012 stop  input  NUM_CH  per-channel abort.
REQ-013 led  output  NUM_CH  registered LED drive, 1 = lit.
REQ-014 busy  output  NUM_CH  channel not IDLE.
REQ-015 done  output  NUM_CH  one-cycle pulse on normal pattern completion.

Function
REQ-016 Prescaler SHALL free-run 0..PRESCALE, wrap to 0, and assert tick for one cycle when count==PRESCALE.
REQ-017 Each channel SHALL be an FSM with states IDLE, ON and OFF, plus phase counter, repeat counter, stored off length and forever flag.
REQ-018 cfg_ready SHALL equal (channel cfg_ch is IDLE) AND NOT stop[cfg_ch], combinationally.
REQ-019 On cfg_valid&&cfg_ready, the channel SHALL enter ON next cycle; phase = max(cfg_on,1), repeat = cfg_repeat, forever = (cfg_repeat==0).
REQ-020 In ON or OFF, phase SHALL decrement by 1 per tick; on the tick where phase==1, the phase SHALL end.
REQ-021 At the end of ON: if stored off ≠0, go to OFF with phase = off; else treat as the end of an OFF phase.
REQ-022 At the end of OFF: if forever, or repeat>1, go to ON with phase = max(on,1), decrementing repeat unless forever; else go to IDLE and pulse done for exactly 1 cycle.
REQ-023 stop[i] SHALL force channel i to IDLE on the next edge, with led[i]=0, no done pulse, and stored config discarded; stop overrides a same-cycle tick.
REQ-024 led[i] SHALL be 1 iff channel i is in ON; busy[i] SHALL be 1 iff channel i is not in IDLE; both are registered, with no combinational path from inputs.
REQ-025 Channels SHALL be fully independent; one config accept per cycle; the prescaler is shared and never restarted by a config.
REQ-026 Because the prescaler is free-running, the first phase after accept SHALL last between (n-1)*(PRESCALE+1)+1 and n*(PRESCALE+1) cycles; later phases last exactly n*(PRESCALE+1).

Reset
REQ-027 While reset is high: prescaler=0, every channel IDLE, led=0, busy=0, done=0, all counters 0; reset overrides all other inputs.
REQ-028 Reset mid-pattern SHALL abort without a done pulse; the first tick after release SHALL occur PRESCALE+1 cycles after the first non-reset edge.

Structure
REQ-029 Package led_ctrl_pkg SHALL hold the channel state enum (IDLE, ON, OFF) and defaults for NUM_CH, PRESCALE and CNT_W.
REQ-030 Prescaler SHALL be sub-module tick_gen (clk, reset, tick); channel FSMs are generated per channel in led_blink_ctrl.

Verification (PRESCALE=3, tick every 4 cycles)
REQ-031 Reset release -> first tick at the 4th edge; led=0, busy=0.
REQ-032 ch0 on=2, off=1, repeat=2, accepted aligned to a tick -> led0 high 8 cycles, low 4, high 8, low 4, then done0 pulses 1 cycle and busy0 falls.
REQ-033 ch1 on=1, off=0, repeat=0 -> led1 stays high forever; stop[1] -> led1=0 and busy1=0 next cycle, no done.
REQ-034 cfg_valid to busy ch0 -> cfg_ready=0 and config ignored; the same request to idle ch2 in the same run is accepted.
REQ-035 cfg accept with stop on the same channel in the same cycle -> cfg_ready=0 and the channel stays IDLE; reset asserted mid-ON on ch3 -> led3=0 next cycle, no done.
